// File: rtl/actuador_puertas.sv
`default_nettype none
// ============================================================================
// Module  : actuador_puertas
// Brief   : Door mechanism model and timer stage. Drives the door motor,
//           tracks travel with a position counter and raises the open-hold
//           timeout consumed by the door controller.
// Revision: 1.0 - initial release
// ============================================================================
module actuador_puertas #(
    parameter int T_MOV     = 20,
    parameter int T_ABIERTA = 100,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    salida_puertas,
    input  logic          sensor,
    output logic [1:0]    puertas,
    output logic          timeout,
    output logic [1:0]    motor,
    output logic [CW-1:0] posicion
);

    typedef enum logic [1:0] {
        CERRADA  = 2'b00,
        ABIERTA  = 2'b01,
        CERRANDO = 2'b10,
        ABRIENDO = 2'b11
    } estado_t;

    localparam logic [CW-1:0] C_TMOV     = CW'(T_MOV);
    localparam logic [CW-1:0] C_TABIERTA = CW'(T_ABIERTA);
    localparam logic [CW-1:0] C_UNO      = CW'(1);

    estado_t       estado_q;
    logic [CW-1:0] pos_q;
    logic [CW-1:0] tmr_q;

    // Command 11 decodes as neither open nor close, i.e. no request.
    logic cmd_abrir;
    logic cmd_cerrar;
    assign cmd_abrir  = (salida_puertas == 2'b01);
    assign cmd_cerrar = (salida_puertas == 2'b10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= CERRADA;
            pos_q    <= '0;
            tmr_q    <= '0;
        end else begin
            case (estado_q)
                CERRADA: begin
                    if (cmd_abrir) begin
                        estado_q <= ABRIENDO;
                    end
                end
                ABRIENDO: begin
                    // A permitted reversal wins over completing the travel.
                    if (cmd_cerrar && !sensor) begin
                        estado_q <= CERRANDO;
                    end else if (pos_q >= C_TMOV - C_UNO) begin
                        pos_q    <= C_TMOV;
                        tmr_q    <= '0;
                        estado_q <= ABIERTA;
                    end else begin
                        pos_q <= pos_q + C_UNO;
                    end
                end
                ABIERTA: begin
                    if (cmd_abrir) begin
                        tmr_q <= '0;
                    end else if (cmd_cerrar) begin
                        tmr_q <= '0;
                        if (!sensor) begin
                            estado_q <= CERRANDO;
                        end
                    end else if (tmr_q != C_TABIERTA) begin
                        tmr_q <= tmr_q + C_UNO;
                    end
                end
                CERRANDO: begin
                    if (sensor || cmd_abrir) begin
                        estado_q <= ABRIENDO;
                    end else if (pos_q <= C_UNO) begin
                        pos_q    <= '0;
                        estado_q <= CERRADA;
                    end else begin
                        pos_q <= pos_q - C_UNO;
                    end
                end
                default: begin
                    estado_q <= CERRADA;
                end
            endcase
        end
    end

    assign puertas  = estado_q;
    assign posicion = pos_q;
    assign timeout  = (estado_q == ABIERTA) && (tmr_q == C_TABIERTA);
    assign motor    = (estado_q == ABRIENDO) ? 2'b01 :
                      (estado_q == CERRANDO) ? 2'b10 : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_actuador_puertas.sv
`default_nettype none
// ============================================================================
// Module  : tb_actuador_puertas
// Brief   : Self-checking bench for actuador_puertas: vector table, directed
//           corner sequences and random stimulus against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_actuador_puertas;

    localparam int T_MOV     = 20;
    localparam int T_ABIERTA = 100;
    localparam int CW        = 8;

    localparam logic [1:0] D_CLOSED  = 2'b00;
    localparam logic [1:0] D_OPEN    = 2'b01;
    localparam logic [1:0] D_CLOSING = 2'b10;
    localparam logic [1:0] D_OPENING = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    salida_puertas = 2'b00;
    logic          sensor = 1'b0;
    logic [1:0]    puertas;
    logic          timeout;
    logic [1:0]    motor;
    logic [CW-1:0] posicion;

    actuador_puertas #(.T_MOV(T_MOV), .T_ABIERTA(T_ABIERTA), .CW(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .salida_puertas (salida_puertas),
        .sensor         (sensor),
        .puertas        (puertas),
        .timeout        (timeout),
        .motor          (motor),
        .posicion       (posicion)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural door: physical position, open-hold age, direction.
    logic [1:0] m_door;
    int         m_pos;
    int         m_hold;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_door = D_CLOSED;
        m_pos  = 0;
        m_hold = 0;
    endtask

    task automatic model_edge(input logic [1:0] cmd, input logic sens);
        bit want_open  = (cmd == 2'b01);
        bit want_close = (cmd == 2'b10);
        if (m_door == D_CLOSED) begin
            if (want_open) m_door = D_OPENING;
        end else if (m_door == D_OPENING) begin
            if (want_close && !sens) m_door = D_CLOSING;
            else begin
                m_pos = (m_pos + 1 > T_MOV) ? T_MOV : m_pos + 1;
                if (m_pos == T_MOV) begin
                    m_door = D_OPEN;
                    m_hold = 0;
                end
            end
        end else if (m_door == D_OPEN) begin
            if (want_open || want_close) m_hold = 0;
            else if (m_hold < T_ABIERTA) m_hold = m_hold + 1;
            if (want_close && !sens) m_door = D_CLOSING;
        end else begin
            if (sens || want_open) m_door = D_OPENING;
            else begin
                m_pos = (m_pos - 1 < 0) ? 0 : m_pos - 1;
                if (m_pos == 0) m_door = D_CLOSED;
            end
        end
    endtask

    function automatic logic [1:0] model_motor();
        return (m_door == D_OPENING) ? 2'b01 : (m_door == D_CLOSING) ? 2'b10 : 2'b00;
    endfunction

    function automatic bit model_timeout();
        return (m_door == D_OPEN) && (m_hold == T_ABIERTA);
    endfunction

    // One clock edge: drive, advance model, compare all outputs one step later.
    task automatic step(input logic [1:0] cmd, input logic sens);
        salida_puertas = cmd;
        sensor         = sens;
        @(posedge clk);
        model_edge(cmd, sens);
        #1;
        n_tests++;
        if (puertas !== m_door || int'(posicion) != m_pos ||
            timeout !== model_timeout() || motor !== model_motor()) begin
            n_fail++;
            $display("FAIL model: got p=%b pos=%0d to=%b m=%b expected p=%b pos=%0d to=%b m=%b at %0t",
                     puertas, posicion, timeout, motor, m_door, m_pos,
                     model_timeout(), model_motor(), $time);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        salida_puertas = 2'b00;
        sensor = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
    endtask

    // Idle with cmd 00 until puertas reaches target; returns edges taken.
    task automatic run_until(input logic [1:0] target, input int bound, output int edges);
        edges = 0;
        while (puertas !== target && edges < bound) begin
            step(2'b00, 1'b0);
            edges++;
        end
    endtask

    typedef struct {
        logic [1:0] cmd;
        logic       sens;
        logic [1:0] e_door;
        int         e_pos;
        logic [1:0] e_motor;
    } vec_t;

    vec_t vt [12];
    int   edges;

    initial begin
        vt[0]  = '{2'b01, 1'b0, D_OPENING, 0, 2'b01};
        vt[1]  = '{2'b00, 1'b0, D_OPENING, 1, 2'b01};
        vt[2]  = '{2'b11, 1'b0, D_OPENING, 2, 2'b01};
        vt[3]  = '{2'b10, 1'b1, D_OPENING, 3, 2'b01};
        vt[4]  = '{2'b10, 1'b0, D_CLOSING, 3, 2'b10};
        vt[5]  = '{2'b00, 1'b0, D_CLOSING, 2, 2'b10};
        vt[6]  = '{2'b01, 1'b0, D_OPENING, 2, 2'b01};
        vt[7]  = '{2'b10, 1'b0, D_CLOSING, 2, 2'b10};
        vt[8]  = '{2'b00, 1'b0, D_CLOSING, 1, 2'b10};
        vt[9]  = '{2'b00, 1'b0, D_CLOSED,  0, 2'b00};
        vt[10] = '{2'b10, 1'b1, D_CLOSED,  0, 2'b00};
        vt[11] = '{2'b11, 1'b0, D_CLOSED,  0, 2'b00};

        model_reset();
        do_reset();
        chk("reset_puertas", int'(puertas), 0);
        chk("reset_pos", int'(posicion), 0);
        chk("reset_motor", int'(motor), 0);
        chk("reset_timeout", int'(timeout), 0);

        for (int i = 0; i < 12; i++) begin
            salida_puertas = vt[i].cmd;
            sensor         = vt[i].sens;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_puertas", i), int'(puertas), int'(vt[i].e_door));
            chk($sformatf("vec%0d_pos", i), int'(posicion), vt[i].e_pos);
            chk($sformatf("vec%0d_motor", i), int'(motor), int'(vt[i].e_motor));
        end

        // Full opening: open state reached T_MOV+1 edges after the command.
        do_reset();
        step(2'b01, 1'b0);
        chk("open_motor", int'(motor), 1);
        run_until(D_OPEN, 40, edges);
        chk("open_latency", edges + 1, T_MOV + 1);
        chk("open_pos", int'(posicion), T_MOV);
        chk("open_motor_stop", int'(motor), 0);

        // Hold timeout: low for T_ABIERTA-1 edges, high from the T_ABIERTA-th.
        for (int i = 0; i < T_ABIERTA - 1; i++) step(2'b00, 1'b0);
        chk("hold_before", int'(timeout), 0);
        step(2'b00, 1'b0);
        chk("hold_at", int'(timeout), 1);
        for (int i = 0; i < 3; i++) step(2'b11, 1'b0);
        chk("hold_kept", int'(timeout), 1);

        // Reopen request restarts the hold.
        step(2'b01, 1'b0);
        chk("reopen_drop", int'(timeout), 0);
        edges = 0;
        while (timeout !== 1'b1 && edges < 200) begin
            step(2'b00, 1'b0);
            edges++;
        end
        chk("reopen_rearm", edges, T_ABIERTA);

        // Sensor blocks closing while open; release then closes fully.
        step(2'b10, 1'b1);
        chk("blocked_puertas", int'(puertas), int'(D_OPEN));
        chk("blocked_timeout", int'(timeout), 0);
        step(2'b10, 1'b0);
        chk("close_start", int'(puertas), int'(D_CLOSING));
        run_until(D_CLOSED, 40, edges);
        chk("close_latency", edges, T_MOV);

        // Sensor reversal while closing at position 12.
        step(2'b01, 1'b0);
        run_until(D_OPEN, 40, edges);
        step(2'b10, 1'b0);
        while (int'(posicion) > 12 && puertas == D_CLOSING) step(2'b00, 1'b0);
        step(2'b00, 1'b1);
        chk("rev_puertas", int'(puertas), int'(D_OPENING));
        chk("rev_pos", int'(posicion), 12);
        chk("rev_motor", int'(motor), 1);
        run_until(D_OPEN, 40, edges);
        chk("rev_reopen_pos", int'(posicion), T_MOV);

        // Asynchronous reset mid-closing at position 7.
        step(2'b10, 1'b0);
        while (int'(posicion) > 7 && puertas == D_CLOSING) step(2'b00, 1'b0);
        chk("pre_rst_pos", int'(posicion), 7);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_puertas", int'(puertas), 0);
        chk("arst_pos", int'(posicion), 0);
        chk("arst_motor", int'(motor), 0);
        chk("arst_timeout", int'(timeout), 0);
        model_reset();
        #8;
        rst_n = 1'b1;

        // Random traffic, mostly idle so travel and hold complete regularly.
        for (int i = 0; i < 4000; i++) begin
            logic [1:0] c;
            logic       s;
            c = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(0, 3));
            s = ($urandom_range(0, 9) == 0);
            step(c, s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/actuador_puertas.md
Name: actuador_puertas

Overview:
Door mechanism model and timer stage that sits directly downstream of the door controller. It consumes the controller's open/close command and drives the door motor. It tracks door travel with a position counter and returns the 2-bit door state plus the open-hold timeout that the controller consumes. All state is registered on one clock.

Parameters:
T_MOV, 20, clock cycles of travel between fully closed and fully open (>=2)
T_ABIERTA, 100, clock cycles the door stays fully open before timeout asserts (>=1)
CW, 8, counter width; must satisfy 2^CW > max(T_MOV, T_ABIERTA)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active low
salida_puertas  input  2  command from door controller: 01 open, 10 close, 00 nothing, 11 treated as 00
sensor  input  1  obstruction between doors (1 = sensed)
puertas  output  2  door state: 00 closed, 01 open, 10 closing, 11 opening
timeout  output  1  door has been fully open for T_ABIERTA cycles
motor  output  2  motor drive: 01 open, 10 close, 00 stop
posicion  output  CW  door position, 0 = closed, T_MOV = fully open

Behaviour:
- Reset (rst_n low, asynchronous): state CERRADA, posicion 0, hold timer 0, so puertas=00, timeout=0, motor=00. Reset mid-travel abandons the motion immediately.
- The 4-state FSM encoding equals puertas: CERRADA=00, ABIERTA=01, CERRANDO=10, ABRIENDO=11.
- All outputs decode registers only; there is no combinational input-to-output path.
- motor=01 in ABRIENDO, 10 in CERRANDO, 00 otherwise.
- Inputs are sampled on a rising edge. The effect appears after that edge, with 1-cycle latency.
- CERRADA:
  - cmd 01 -> ABRIENDO; posicion stays 0.
  - Anything else -> stay. sensor is ignored.
- ABRIENDO:
  - Each edge, posicion+1.
  - When posicion+1 == T_MOV: posicion=T_MOV, go ABIERTA, hold timer cleared to 0.
  - cmd 10 with sensor=0 -> CERRANDO from the current posicion (reversal, no increment that cycle).
  - sensor=1 blocks reversal.
- ABIERTA:
  - Hold timer +1 per edge, saturating at T_ABIERTA.
  - timeout = (state==ABIERTA && timer==T_ABIERTA). It stays high until ABIERTA is left or cmd 01 arrives.
  - cmd 01 -> timer reset to 0 (reopen request restarts hold); timeout drops the next cycle.
  - cmd 10 with sensor=0 -> CERRANDO, timer cleared.
  - cmd 10 with sensor=1 -> stay, timer reset to 0.
- CERRANDO:
  - Each edge, posicion-1.
  - When posicion-1 == 0: posicion=0, go CERRADA.
  - sensor=1 OR cmd 01 -> ABRIENDO from the current posicion, no decrement that cycle. Sensor has priority over cmd 10.
- Simultaneous events: sensor beats close in every state. Completion of travel and a reversal in the same cycle resolve in favour of the reversal, except in CERRADA and ABIERTA, where the rules above apply.
- posicion never leaves 0..T_MOV.
- Timing from fully closed: door reads 01 exactly T_MOV+1 edges after the open command is sampled. timeout rises T_ABIERTA edges after entering ABIERTA.

Test Plan:
1. Reset, then cmd 01 for 1 cycle, then 00 (T_MOV=20) -> puertas 11 one cycle later; posicion ramps 1..20; puertas=01 on edge 21; motor=01 during travel, then 00.
2. Door open, cmd 00 held (T_ABIERTA=100) -> timeout=0 for 99 cycles, 1 from the 100th cycle and held; then cmd 10 -> puertas=10, timeout=0 the next cycle.
3. Closing at posicion=12, sensor pulses 1 -> next cycle puertas=11, posicion=12, motor=01; the door reopens to 20.
4. Door open, sensor=1 with cmd 10 -> stays 01, timer restarts; sensor released with cmd 10 -> 10, and reaches 00 after 20 cycles.
5. Open at timeout=1, cmd 01 one cycle -> timeout=0 the next cycle, re-asserts 100 cycles later. cmd 11 at any state -> no effect.
6. Assert rst_n=0 asynchronously mid-closing at posicion=7 -> puertas=00, posicion=0, motor=00, timeout=0 immediately, without waiting for a clock edge.
